// File: rtl/piradip_bit_frame_sync.sv
// piradip_bit_frame_sync
// Frame synchroniser for a one-bit piradip_bit_stream. It hunts for SYNC_WORD,
// strips every sync word, and forwards only the FRAME_BITS payload bits of
// each frame. Before each frame's payload, align pulses for one cycle so that
// the downstream piradip_bit_to_stream packer can start a new word there.
// After lock, a missed sync word is flywheeled: the frame window stays where
// it was. Lock is dropped after MISS_LIMIT consecutive misses.
//
// Handshake: a beat moves on a stream when tvalid & tready are both high at
// posedge clk. A source holds tdata/tlast steady while tvalid is high and
// tready is low. tready never depends on tvalid on the same stream. Here
// bits_in is always ready in HUNT/CHECK, never ready in ALIGN, and in PAYLOAD
// it mirrors bits_out_tready, with data passing straight through.
module piradip_bit_frame_sync #(
  parameter int                    SYNC_WIDTH = 32,
  parameter logic [SYNC_WIDTH-1:0] SYNC_WORD  = 32'h1ACFFC1D,
  parameter int                    FRAME_BITS = 1024,
  parameter int                    MISS_LIMIT = 3,
  parameter int                    MAX_ERRORS = 0
) (
  input  logic        clk,
  input  logic        rstn,
  // piradip_bit_stream subordinate (tlast is not used)
  input  logic        bits_in_tvalid,
  output logic        bits_in_tready,
  input  logic        bits_in_tdata,
  input  logic        bits_in_tlast,
  // piradip_bit_stream manager (payload only)
  output logic        bits_out_tvalid,
  input  logic        bits_out_tready,
  output logic        bits_out_tdata,
  output logic        bits_out_tlast,
  // status
  output logic        align,
  output logic        locked,
  output logic        sync_lost,
  output logic [15:0] miss_count,
  // FSM state for observation: 0 HUNT, 1 ALIGN, 2 PAYLOAD, 3 CHECK
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ALIGN   = 2'd1,
    PAYLOAD = 2'd2,
    CHECK   = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(SYNC_WIDTH + 1);
  localparam int PAY_W = $clog2(FRAME_BITS);
  localparam int RUN_W = $clog2(MISS_LIMIT + 1);

  // HUNT needs SYNC_WIDTH-1 earlier bits plus the current one before a match
  // counts, so the cleared history register cannot produce a false lock.
  localparam logic [CNT_W-1:0] FILL_MIN  = CNT_W'(SYNC_WIDTH - 1);
  localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(SYNC_WIDTH);
  localparam logic [CNT_W-1:0] CHK_LAST  = CNT_W'(SYNC_WIDTH - 1);
  localparam logic [PAY_W-1:0] PAY_LAST  = PAY_W'(FRAME_BITS - 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MISS_LIMIT);

  state_t                state;
  state_t                next_state;

  // The candidate word is made from the incoming bit and the previous
  // SYNC_WIDTH-1 bits, so only those bits need to be stored.
  logic [SYNC_WIDTH-2:0] sr;
  logic [SYNC_WIDTH-1:0] cand;
  logic [CNT_W-1:0]      fill;
  logic [CNT_W-1:0]      bit_cnt;
  logic [PAY_W-1:0]      pay_cnt;
  logic [RUN_W-1:0]      miss_run;
  logic [RUN_W-1:0]      miss_run_inc;

  logic                  xfer_in;
  logic                  match;
  logic                  fill_ok;
  logic                  last_payload;
  logic                  check_done;
  logic                  run_exhausted;
  logic                  tlast_unused;

  // Number of bit positions where v is 1, i.e. the Hamming weight.
  function automatic int hamming(input logic [SYNC_WIDTH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < SYNC_WIDTH; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

  assign tlast_unused  = bits_in_tlast;
  assign xfer_in       = bits_in_tvalid & bits_in_tready;
  assign cand          = {sr, bits_in_tdata};
  assign match         = hamming(cand ^ SYNC_WORD) <= MAX_ERRORS;
  assign fill_ok       = fill >= FILL_MIN;
  assign last_payload  = pay_cnt == PAY_LAST;
  assign check_done    = bit_cnt == CHK_LAST;
  assign miss_run_inc  = miss_run + RUN_W'(1);
  assign run_exhausted = miss_run_inc == RUN_LIMIT;
  assign fsm_state     = state;

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= HUNT;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: all decisions happen on accepted input bits, except
  // ALIGN, which always lasts exactly one cycle.
  always_comb begin
    next_state = state;
    unique case (state)
      HUNT: begin
        if (xfer_in && match && fill_ok) next_state = ALIGN;
      end
      ALIGN: begin
        next_state = PAYLOAD;
      end
      PAYLOAD: begin
        if (xfer_in && last_payload) next_state = CHECK;
      end
      CHECK: begin
        if (xfer_in && check_done) begin
          if (match || !run_exhausted) next_state = ALIGN;
          else                         next_state = HUNT;
        end
      end
      default: next_state = HUNT;
    endcase
  end

  // Output logic: the stream handshakes and the align pulse depend only on
  // the state, except for the pass-through during PAYLOAD.
  always_comb begin
    bits_in_tready  = 1'b0;
    bits_out_tvalid = 1'b0;
    bits_out_tdata  = bits_in_tdata;
    bits_out_tlast  = 1'b0;
    align           = 1'b0;
    unique case (state)
      HUNT:    bits_in_tready = 1'b1;
      ALIGN:   align          = 1'b1;
      PAYLOAD: begin
        bits_in_tready  = bits_out_tready;
        bits_out_tvalid = bits_in_tvalid;
        bits_out_tlast  = last_payload;
      end
      CHECK:   bits_in_tready = 1'b1;
      default: bits_in_tready = 1'b0;
    endcase
  end

  // Datapath: sync history, frame counters, lock and miss bookkeeping. While
  // the input stalls, nothing here changes.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sr         <= '0;
      fill       <= '0;
      bit_cnt    <= '0;
      pay_cnt    <= '0;
      miss_run   <= '0;
      miss_count <= '0;
      locked     <= 1'b0;
      sync_lost  <= 1'b0;
    end else begin
      sync_lost <= 1'b0;
      unique case (state)
        HUNT: begin
          if (xfer_in) begin
            sr <= cand[SYNC_WIDTH-2:0];
            if (fill != FILL_FULL) fill <= fill + CNT_W'(1);
            if (match && fill_ok) begin
              locked   <= 1'b1;
              miss_run <= '0;
            end
          end
        end
        ALIGN: begin
          pay_cnt <= '0;
        end
        PAYLOAD: begin
          if (xfer_in) begin
            pay_cnt <= pay_cnt + PAY_W'(1);
            if (last_payload) bit_cnt <= '0;
          end
        end
        CHECK: begin
          if (xfer_in) begin
            sr      <= cand[SYNC_WIDTH-2:0];
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (check_done) begin
              if (match) begin
                miss_run <= '0;
              end else begin
                if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                if (run_exhausted) begin
                  // Too many misses in a row: give up the window and hunt again.
                  locked    <= 1'b0;
                  sync_lost <= 1'b1;
                  fill      <= '0;
                  miss_run  <= '0;
                end else begin
                  miss_run <= miss_run_inc;
                end
              end
            end
          end
        end
        default: begin
          fill <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piradip_bit_frame_sync.sv
// Testbench for piradip_bit_frame_sync (SYNC_WIDTH=8, SYNC_WORD=A5,
// FRAME_BITS=16, MISS_LIMIT=2). A second instance built with MAX_ERRORS=1
// covers tolerant matching. The bench keeps a frame-level reference model: it
// walks the sent bit sequence (hunt window, payload run, sync window) and
// queues the expected payload bits.
module tb_piradip_bit_frame_sync;

  localparam int         SW    = 8;
  localparam logic [7:0] SWORD = 8'hA5;
  localparam int         FB    = 16;
  localparam int         ML    = 2;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic in_tvalid  = 1'b0;
  logic in_tdata   = 1'b0;
  logic in_tlast   = 1'b0;
  logic out_tready = 1'b1;
  logic use_me1    = 1'b0;
  logic rand_ready = 1'b0;

  logic        a_in_tready, a_out_tvalid, a_out_tdata, a_out_tlast;
  logic        a_align, a_locked, a_sync_lost;
  logic [15:0] a_miss;
  logic [1:0]  a_state;
  logic        b_in_tready, b_out_tvalid, b_out_tdata, b_out_tlast;
  logic        b_align, b_locked, b_sync_lost;
  logic [15:0] b_miss;
  logic [1:0]  b_state;

  piradip_bit_frame_sync #(
    .SYNC_WIDTH(SW), .SYNC_WORD(SWORD), .FRAME_BITS(FB), .MISS_LIMIT(ML), .MAX_ERRORS(0)
  ) dut (
    .clk(clk), .rstn(rstn),
    .bits_in_tvalid(in_tvalid), .bits_in_tready(a_in_tready),
    .bits_in_tdata(in_tdata), .bits_in_tlast(in_tlast),
    .bits_out_tvalid(a_out_tvalid), .bits_out_tready(out_tready),
    .bits_out_tdata(a_out_tdata), .bits_out_tlast(a_out_tlast),
    .align(a_align), .locked(a_locked), .sync_lost(a_sync_lost),
    .miss_count(a_miss), .fsm_state(a_state)
  );

  piradip_bit_frame_sync #(
    .SYNC_WIDTH(SW), .SYNC_WORD(SWORD), .FRAME_BITS(FB), .MISS_LIMIT(ML), .MAX_ERRORS(1)
  ) dut_me1 (
    .clk(clk), .rstn(rstn),
    .bits_in_tvalid(in_tvalid), .bits_in_tready(b_in_tready),
    .bits_in_tdata(in_tdata), .bits_in_tlast(in_tlast),
    .bits_out_tvalid(b_out_tvalid), .bits_out_tready(out_tready),
    .bits_out_tdata(b_out_tdata), .bits_out_tlast(b_out_tlast),
    .align(b_align), .locked(b_locked), .sync_lost(b_sync_lost),
    .miss_count(b_miss), .fsm_state(b_state)
  );

  // The instance under observation
  logic        in_tready, out_tvalid, out_tdata, out_tlast, align, locked, sync_lost;
  logic [15:0] miss_count;
  logic [1:0]  fsm_state;
  assign in_tready  = use_me1 ? b_in_tready  : a_in_tready;
  assign out_tvalid = use_me1 ? b_out_tvalid : a_out_tvalid;
  assign out_tdata  = use_me1 ? b_out_tdata  : a_out_tdata;
  assign out_tlast  = use_me1 ? b_out_tlast  : a_out_tlast;
  assign align      = use_me1 ? b_align      : a_align;
  assign locked     = use_me1 ? b_locked     : a_locked;
  assign sync_lost  = use_me1 ? b_sync_lost  : a_sync_lost;
  assign miss_count = use_me1 ? b_miss       : a_miss;
  assign fsm_state  = use_me1 ? b_state      : a_state;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  // m_mode: 0 hunting, 1 inside payload, 2 collecting a sync window
  int         m_mode   = 0;
  int         m_pcount = 0;
  int         m_run    = 0;
  int         m_misses = 0;
  int         m_align  = 0;
  int         m_lost   = 0;
  logic       m_locked = 1'b0;
  logic       hist[$];
  logic [1:0] exp_q[$];   // {tlast, tdata}

  function automatic int hist_dist();
    logic [SW-1:0] w;
    for (int i = 0; i < SW; i++) w[SW-1-i] = hist[hist.size()-SW+i];
    return $countones(w ^ SWORD);
  endfunction

  function automatic void model_clear();
    m_mode = 0; m_pcount = 0; m_run = 0; m_misses = 0;
    m_align = 0; m_lost = 0; m_locked = 1'b0;
    hist.delete();
    exp_q.delete();
  endfunction

  function automatic void model_push(input logic b);
    int me;
    me = use_me1 ? 1 : 0;
    case (m_mode)
      0: begin
        hist.push_back(b);
        if (hist.size() > SW) void'(hist.pop_front());
        if (hist.size() == SW && hist_dist() <= me) begin
          m_locked = 1'b1; m_run = 0; m_align++; m_mode = 1; m_pcount = 0;
          hist.delete();
        end
      end
      1: begin
        exp_q.push_back({(m_pcount == FB - 1), b});
        m_pcount++;
        if (m_pcount == FB) begin
          m_mode = 2;
          hist.delete();
        end
      end
      default: begin
        hist.push_back(b);
        if (hist.size() == SW) begin
          if (hist_dist() <= me) begin
            m_run = 0; m_align++; m_mode = 1; m_pcount = 0;
          end else begin
            m_misses++;
            if (m_run + 1 < ML) begin
              m_run++; m_align++; m_mode = 1; m_pcount = 0;
            end else begin
              m_lost++; m_locked = 1'b0; m_mode = 0;
            end
          end
          hist.delete();
        end
      end
    endcase
  endfunction

  // ---------------- output monitor / scoreboard ----------------
  int          seen_align = 0;
  int          seen_lost  = 0;
  logic [15:0] cap        = '0;
  logic        stall_prev = 1'b0;
  logic [1:0]  stall_val  = '0;

  always @(negedge clk) begin
    logic [1:0] e;
    #2;
    if (rstn) begin
      if (align) seen_align++;
      if (sync_lost) seen_lost++;
      if (stall_prev && out_tvalid) begin
        vectors++;
        if ({out_tlast, out_tdata} !== stall_val) begin
          miscompares++;
          $display("FAIL stall_hold: got %b, required %b", {out_tlast, out_tdata}, stall_val);
        end
      end
      if (out_tvalid && out_tready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL out_extra: got bit %b tlast %b, required no output", out_tdata, out_tlast);
        end else begin
          e = exp_q.pop_front();
          if ({out_tlast, out_tdata} !== e) begin
            miscompares++;
            $display("FAIL out_bit: got {tlast,bit}=%b, required %b", {out_tlast, out_tdata}, e);
          end
        end
        cap = {cap[14:0], out_tdata};
      end
      stall_prev = out_tvalid && !out_tready;
      stall_val  = {out_tlast, out_tdata};
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Random downstream backpressure bursts
  int burst_left = 0;
  always @(negedge clk) begin
    if (!rand_ready) begin
      out_tready = 1'b1;
      burst_left = 0;
    end else if (burst_left > 0) begin
      out_tready = 1'b0;
      burst_left--;
    end else if ($urandom_range(99) < 20) begin
      out_tready = 1'b0;
      burst_left = $urandom_range(4, 1) - 1;
    end else begin
      out_tready = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; in_tvalid = 1'b0;
    model_clear();
    @(negedge clk);
    rstn = 1'b1;
    seen_align = 0; seen_lost = 0; cap = '0;
  endtask

  task automatic send_bit(input logic b, input int gap_pct);
    bit done;
    done = 1'b0;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      in_tvalid = 1'b0;
      @(negedge clk);
    end
    in_tvalid = 1'b1; in_tdata = b;
    model_push(b);
    for (int t = 0; t < 200 && !done; t++) begin
      #1;
      if (in_tready) done = 1'b1;
      @(negedge clk);
    end
    in_tvalid = 1'b0;
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: got tready=0 for 200 cycles, required acceptance");
    end
  endtask

  task automatic send_bits(input logic [15:0] v, input int n, input int gap_pct);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], gap_pct);
  endtask

  task automatic idle(input int n);
    in_tvalid = 1'b0;
    repeat (n) @(negedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    #1;
    vectors++;
    if ({fsm_state, align, locked, sync_lost, out_tvalid, in_tready} !== 7'b00_0000_1) begin
      miscompares++;
      $display("FAIL reset_flags: got {state,align,locked,lost,ovalid,iready}=%b, required 0000001",
               {fsm_state, align, locked, sync_lost, out_tvalid, in_tready});
    end
    vectors++;
    if (miss_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_miss_count: got %0d, required 0", miss_count);
    end
  endtask

  task automatic test_first_lock();
    logic [27:0] s;
    bit ok;
    for (int tries = 0; tries < 1000; tries++) begin
      s = {20'($urandom()), SWORD};
      ok = 1'b1;
      for (int p = 1; p <= 20; p++) if (s[p +: 8] == SWORD) ok = 1'b0;
      if (ok) break;
    end
    for (int i = 27; i >= 0; i--) send_bit(s[i], 0);
    send_bits(16'hBEEF, 16, 0);
    idle(3);
    vectors++;
    if (cap !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL first_payload: got %h, required beef", cap);
    end
    vectors++;
    if ({seen_align[7:0], seen_lost[7:0], locked, miss_count} !== {8'd1, 8'd0, 1'b1, 16'd0}) begin
      miscompares++;
      $display("FAIL first_lock: got align=%0d lost=%0d locked=%b miss=%0d, required 1 0 1 0",
               seen_align, seen_lost, locked, miss_count);
    end
  endtask

  task automatic test_frames(input string name, input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input int nframes, input int gap_pct);
    logic [7:0] syncs [3];
    syncs[0] = s0; syncs[1] = s1; syncs[2] = s2;
    for (int f = 0; f < nframes; f++) begin
      send_bits({8'h00, syncs[f]}, 8, gap_pct);
      send_bits(16'($urandom()), 16, gap_pct);
    end
    idle(3);
    vectors++;
    if ({seen_align[7:0], seen_lost[7:0], locked, miss_count} !==
        {m_align[7:0], m_lost[7:0], m_locked, 16'(m_misses)}) begin
      miscompares++;
      $display("FAIL %s_totals: got align=%0d lost=%0d locked=%b miss=%0d, required %0d %0d %b %0d",
               name, seen_align, seen_lost, locked, miss_count, m_align, m_lost, m_locked, m_misses);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d bits still expected, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_loss_relock();
    do_reset();
    send_bits(16'h00A5, 8, 0);
    send_bits(16'($urandom()), 16, 0);
    test_frames("loss", 8'h00, 8'h00, 8'h00, 1, 0);
    send_bits(16'h0000, 8, 0);
    idle(3);
    vectors++;
    if ({seen_lost[7:0], locked, miss_count} !== {8'd1, 1'b0, 16'd2}) begin
      miscompares++;
      $display("FAIL loss_state: got lost=%0d locked=%b miss=%0d, required 1 0 2",
               seen_lost, locked, miss_count);
    end
    send_bits(16'h00A5, 8, 0);
    vectors++;
    if (locked !== 1'b1 || fsm_state === 2'd0) begin
      miscompares++;
      $display("FAIL relock: got locked=%b state=%0d, required locked=1 after 8 bits", locked, fsm_state);
    end
    send_bits(16'($urandom()), 16, 0);
    idle(3);
  endtask

  task automatic test_max_errors();
    use_me1 = 1'b1;
    do_reset();
    test_frames("me1_accept", 8'hA5, 8'hA4, 8'hA5, 2, 0);
    vectors++;
    if (miss_count !== 16'd0) begin
      miscompares++;
      $display("FAIL me1_a4: got miss=%0d, required 0", miss_count);
    end
    test_frames("me1_reject", 8'hA6, 8'hA5, 8'hA5, 1, 0);
    vectors++;
    if (miss_count !== 16'd1 || locked !== 1'b1) begin
      miscompares++;
      $display("FAIL me1_a6: got miss=%0d locked=%b, required 1 1", miss_count, locked);
    end
    use_me1 = 1'b0;
  endtask

  task automatic test_stall_reset();
    do_reset();
    rand_ready = 1'b1;
    send_bits(16'h00A5, 8, 30);
    send_bits(16'($urandom()), 16, 30);
    send_bits(16'h0000, 8, 30);
    send_bits(16'($urandom()), 16, 30);
    send_bits(16'h00A5, 8, 30);
    send_bits(16'($urandom()), 7, 30);
    vectors++;
    if (exp_q.size() != 0 || seen_align != 3 || miss_count !== 16'd1) begin
      miscompares++;
      $display("FAIL stall_prereset: got pending=%0d align=%0d miss=%0d, required 0 3 1",
               exp_q.size(), seen_align, miss_count);
    end
    rand_ready = 1'b0;
    do_reset();
    #1;
    vectors++;
    if ({fsm_state, align, locked, sync_lost, out_tvalid, miss_count} !== 22'd0) begin
      miscompares++;
      $display("FAIL midframe_reset: got state=%0d align=%b locked=%b lost=%b ovalid=%b miss=%0d, required all 0",
               fsm_state, align, locked, sync_lost, out_tvalid, miss_count);
    end
  endtask

  initial begin
    test_reset();
    test_first_lock();
    test_frames("three_frames", 8'hA5, 8'hA5, 8'hA5, 3, 0);
    test_frames("flywheel", 8'hA5, 8'h00, 8'hA5, 3, 0);
    test_loss_relock();
    test_max_errors();
    test_stall_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500000, required finish");
    $fatal(1);
  end

endmodule
